// File: rtl/button_event_decoder.sv
// rtl/button_event_decoder.sv - keypad synchroniser, debouncer and press-event queue
//
// Turns N active-low raw buttons into a debounced 1-based key code and a
// one-entry press-event slot with a valid/ready handshake.
//
// Optional feature macro: BUTTON_REPEAT_EN (auto-repeat events while a key is held).
//
// Ports:
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   buttons_n   in   [N_BUTTONS-1:0] raw buttons, active-low, asynchronous to clk
//   value       out  [VAL_W-1:0] debounced code: k+1 when only button k pressed, else 0
//   evt_valid   out  event slot occupied
//   evt_value   out  [VAL_W-1:0] code of the pending event
//   evt_repeat  out  pending event came from auto-repeat
//   evt_ready   in   consumer accepts the event when evt_valid & evt_ready
//   evt_drop    out  one-cycle pulse: an event was lost because the slot was full

module button_event_decoder #(
    parameter int N_BUTTONS       = 16,
    parameter int VAL_W           = $clog2(N_BUTTONS + 1),
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N_BUTTONS-1:0] buttons_n,
    output logic [VAL_W-1:0]     value,
    output logic                 evt_valid,
    output logic [VAL_W-1:0]     evt_value,
    output logic                 evt_repeat,
    input  logic                 evt_ready,
    output logic                 evt_drop
);

    // Elaboration-time parameter sanity check.
    if (N_BUTTONS < 1 || N_BUTTONS > 64 || DEBOUNCE_CYCLES < 2 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 ||
        VAL_W < $clog2(N_BUTTONS + 1)) begin : g_bad_params
        $error("button_event_decoder: parameter out of range");
    end

    localparam int              DB_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HELD   = 2'd1;
`ifdef BUTTON_REPEAT_EN
    localparam logic [1:0] ST_REPEAT = 2'd2;

    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = (RPT_MAX > 2) ? $clog2(RPT_MAX) : 1;
    localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);
`endif

    // ------------------------------------------------------------------
    // Two-flop synchroniser; inversion happens before the first flop so
    // nothing sits between the two stages.
    // ------------------------------------------------------------------
    logic [N_BUTTONS-1:0] sync1;
    logic [N_BUTTONS-1:0] sync2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= ~buttons_n;
            sync2 <= sync1;
        end
    end

    // ------------------------------------------------------------------
    // Candidate decode: exactly one pressed bit -> its 1-based index,
    // otherwise 0 so that chords look like a release.
    // ------------------------------------------------------------------
    logic [VAL_W-1:0] candidate;
    logic [VAL_W-1:0] one_code;
    logic             seen;
    logic             multi;

    always_comb begin
        one_code = '0;
        seen     = 1'b0;
        multi    = 1'b0;
        for (int i = 0; i < N_BUTTONS; i++) begin
            if (sync2[i]) begin
                if (seen) begin
                    multi = 1'b1;
                end
                seen     = 1'b1;
                one_code = VAL_W'(i + 1);
            end
        end
        candidate = (seen && !multi) ? one_code : '0;
    end

    // ------------------------------------------------------------------
    // Debounce: counter restarts whenever the candidate moves and
    // saturates once it has been stable long enough; value follows
    // cand_q only while the counter sits at its terminal count.
    // ------------------------------------------------------------------
    logic [VAL_W-1:0] cand_q;
    logic [DB_W-1:0]  db_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cand_q <= '0;
            db_cnt <= '0;
            value  <= '0;
        end else begin
            cand_q <= candidate;
            if (candidate != cand_q) begin
                db_cnt <= '0;
            end else if (db_cnt != DB_LAST) begin
                db_cnt <= db_cnt + 1'b1;
            end
            if (db_cnt == DB_LAST) begin
                value <= cand_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Press FSM: events are produced only on transitions into a new
    // nonzero key (or by the repeat timer); release is silent.
    // ------------------------------------------------------------------
    logic [1:0]       state;
    logic [1:0]       state_d;
    logic [VAL_W-1:0] key_q;
    logic [VAL_W-1:0] key_d;
    logic             emit;
`ifdef BUTTON_REPEAT_EN
    logic             emit_rpt;
    logic [RPT_W-1:0] rpt_cnt;
    logic [RPT_W-1:0] rpt_cnt_d;
`endif

    always_comb begin
        state_d = state;
        key_d   = key_q;
        emit    = 1'b0;
`ifdef BUTTON_REPEAT_EN
        emit_rpt  = 1'b0;
        rpt_cnt_d = rpt_cnt + 1'b1;
`endif
        if (state == ST_IDLE) begin
`ifdef BUTTON_REPEAT_EN
            rpt_cnt_d = '0;
`endif
            if (value != '0) begin
                emit    = 1'b1;
                key_d   = value;
                state_d = ST_HELD;
            end
        end else begin
            if (value == '0) begin
                state_d = ST_IDLE;
            end else if (value != key_q) begin
                // Rolling straight from one key to another is a fresh press.
                emit    = 1'b1;
                key_d   = value;
                state_d = ST_HELD;
`ifdef BUTTON_REPEAT_EN
                rpt_cnt_d = '0;
            end else if (state == ST_HELD && rpt_cnt == RPT_DELAY_LAST) begin
                emit      = 1'b1;
                emit_rpt  = 1'b1;
                state_d   = ST_REPEAT;
                rpt_cnt_d = '0;
            end else if (state == ST_REPEAT && rpt_cnt == RPT_PERIOD_LAST) begin
                emit      = 1'b1;
                emit_rpt  = 1'b1;
                rpt_cnt_d = '0;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            key_q <= '0;
        end else begin
            state <= state_d;
            key_q <= key_d;
        end
    end

`ifdef BUTTON_REPEAT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rpt_cnt <= '0;
        end else begin
            rpt_cnt <= rpt_cnt_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // One-entry event slot. A new event may replace the entry in the same
    // cycle it is accepted (no bubble); otherwise a full slot keeps the
    // old entry and the new event is reported as dropped.
    // ------------------------------------------------------------------
    logic slot_free;
    assign slot_free = !evt_valid || evt_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            evt_valid <= 1'b0;
            evt_value <= '0;
            evt_drop  <= 1'b0;
        end else begin
            evt_drop <= emit && !slot_free;
            if (emit && slot_free) begin
                evt_valid <= 1'b1;
                evt_value <= value;
            end else if (evt_valid && evt_ready) begin
                evt_valid <= 1'b0;
            end
        end
    end

`ifdef BUTTON_REPEAT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            evt_repeat <= 1'b0;
        end else if (emit && slot_free) begin
            evt_repeat <= emit_rpt;
        end
    end
`else
    assign evt_repeat = 1'b0;
`endif

endmodule
